lsu_mem_responder: RTL and testbench
====================================

# lsu_mem_responder

Load-store responder at the MEM stage: the responder side of the `lsu_VALID`/`lsu_READY` handshake that the hazard controller consumes.
- Accepts one load/store request from the EX/MEM register.
- Performs the access on a req/gnt/rvalid data bus.
- Aligns and sign-extends load data.
- Holds `READY` and the result until the pipeline actually advances MEM→WB.
- While a request is outstanding with `READY` low, the pipeline stalls upstream.

## Interface
- `BUS_TIMEOUT`, default 255: max cycles in WAIT for `i_bus_rvalid` before the access is aborted with error. 0 disables the timeout.
- `i_clk` in 1: clock; one clock domain, all state on its rising edge.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_lsu_VALID` in 1: MEM stage holds a load/store; held with stable payload until accepted.
- `i_lsu_we` in 1: 1 = store, 0 = load.
- `i_lsu_funct3` in 3: RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_lsu_addr` in 32: byte address.
- `i_lsu_wdata` in 32: store data, LSB-aligned.
- `i_adv` in 1: MEM/WB register enable this cycle; the pipeline consumes the result.
- `o_lsu_READY` out 1: result valid; pipeline may advance.
- `o_lsu_rdata` out 32: extended load data; 0 for stores and errors.
- `o_lsu_err` out 1: misaligned, illegal funct3, or bus timeout; qualified by `READY`.
- `o_bus_req` out 1: bus request, held until `i_bus_gnt`.
- `o_bus_we` out 1: bus write.
- `o_bus_addr` out 32: word-aligned address (`[1:0]` = 0).
- `o_bus_be` out 4: byte enables.
- `o_bus_wdata` out 32: lane-replicated store data.
- `i_bus_gnt` in 1: request accepted; sampled only while `o_bus_req` = 1.
- `i_bus_rvalid` in 1: response for granted request; every request, read or write, gets exactly one.
- `i_bus_rdata` in 32: read word, valid with `i_bus_rvalid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE, `i_lsu_VALID`=1:
  - Latch `we`, `funct3`, `addr`, `wdata`.
  - Illegal funct3 (011, 110, 111, or store with 1xx) → DONE with err=1. No bus access.
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0 → DONE with err=1. No bus access.
  - Otherwise → REQ, with `o_bus_req`=1 and bus fields driven from the latch.
- REQ:
  - `i_bus_gnt`=1 → WAIT, `o_bus_req` drops next cycle.
  - Bus fields are stable while in REQ.
  - No timeout in REQ.
- WAIT:
  - Counter cleared on entry and incremented each cycle.
  - `i_bus_rvalid`=1 → DONE: capture extended data (loads) or 0 (stores), err=0.
  - Counter reaching `BUS_TIMEOUT` without rvalid → DONE with err=1, rdata=0.
  - A late rvalid after timeout is ignored.
- DONE:
  - `o_lsu_READY`=1; rdata and err stable.
  - `i_adv`=1 → IDLE.
  - `i_adv`=0 (pipeline frozen by hold-all) → stay in DONE; the result is never lost or repeated.
- Byte lane / enables, with `a = addr[1:0]`:
  - B: `be = 1<<a`.
  - H: `be = 3<<a`.
  - W: `be = 4'hF`.
  - Store wdata: B `{4{wdata[7:0]}}`, H `{2{wdata[15:0]}}`, W as-is.
- Load extraction: select byte `rdata[8a+7:8a]` or half `rdata[8a+15:8a]`.
  - funct3 bit2 = 0: sign-extend.
  - funct3 bit2 = 1: zero-extend.
- `i_lsu_VALID` is not re-sampled outside IDLE. The pipeline guarantees the payload is stable until `READY`·`i_adv`.
- `i_bus_rvalid` in IDLE, REQ or DONE is ignored.

## Timing
- Reset (synchronous):
  - state = IDLE.
  - `o_lsu_READY`=0, `o_lsu_rdata`=0, `o_lsu_err`=0.
  - `o_bus_req`=0, `o_bus_we`=0, `o_bus_addr`=0, `o_bus_be`=0, `o_bus_wdata`=0.
  - Timeout counter = 0.
- Reset mid-transaction abandons the access; the eventual rvalid is dropped.
- Minimum latency, with `VALID` at cycle T:
  - `req` at T+1.
  - `gnt` at T+1.
  - `rvalid` at T+2.
  - `READY` at T+3.
  - Next request accepted at T+4 after `i_adv` at T+3.
- Error path: `VALID` at T → `READY`+err at T+1.
- `READY` is high exactly for the cycles in DONE. It falls the cycle after `i_adv`=1.
- Back-to-back: a `VALID` present in the cycle the FSM returns to IDLE is accepted that cycle.

## Test plan
- LB at `addr 0x1003`, bus returns `0x80FF_FF12` (gnt immediate, rvalid next cycle) → `o_bus_addr 0x1000`, be 4'b1000, `READY` at T+3, rdata `0xFFFF_FF80`, err 0.
- LHU at `0x2002`, rdata `0x8001_1234`, gnt delayed 3 cycles → req held stable 4 cycles, rdata `0x0000_8001`.
- SB at `0x3001`, wdata `0x0000_00AB` → be 4'b0010, bus wdata `0xABAB_ABAB`, we 1, `READY` after rvalid, rdata 0.
- LW at `0x4002` → no `o_bus_req`, `READY`+err at T+1, rdata 0; same for funct3 011.
- LW granted, rvalid never arrives, `BUS_TIMEOUT`=4 → `READY`+err after 4 WAIT cycles; late rvalid ignored; next request serviced normally.
- DONE with `i_adv`=0 for 5 cycles → `READY`/rdata constant; `i_adv` pulse → IDLE next cycle; also assert `i_rst` during WAIT → all outputs 0 next cycle, stray rvalid ignored.

Source files
------------

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
// MEM-stage load/store responder. It takes one request from the EX/MEM
// register, performs it on a req/gnt/rvalid data bus, then presents the
// aligned and extended result with o_lsu_READY. The result is held until the
// pipeline advances (i_adv).
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_lsu_*              request from MEM: valid, we, funct3, addr, wdata
//   i_adv                MEM/WB register enable (result consumed)
//   o_lsu_READY/rdata/err  result towards the pipeline
//   o_bus_req/we/addr/be/wdata  bus request (word aligned, lane replicated)
//   i_bus_gnt/rvalid/rdata      bus grant and response
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_lsu_VALID; decodes and latches the request
// REQ   | o_bus_req high, bus fields stable, waiting for i_bus_gnt
// WAIT  | granted, counting cycles until i_bus_rvalid or timeout
// DONE  | o_lsu_READY high, result held until i_adv
module lsu_mem_responder #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_VALID,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic        i_adv,
  output logic        o_lsu_READY,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  // Counter only needs to reach BUS_TIMEOUT-1: the timeout fires on the
  // WAIT cycle where it holds that value, giving exactly BUS_TIMEOUT WAIT cycles.
  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int TO_LAST_I = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam bit TO_EN = (BUS_TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;

  logic illegal;
  logic misaligned;

  // Store with funct3[2]=1 has no unsigned variant and is illegal.
  assign illegal = (i_lsu_funct3 == 3'b011) || (i_lsu_funct3[2:1] == 2'b11) ||
                   (i_lsu_we && i_lsu_funct3[2]);
  assign misaligned = ((i_lsu_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
                      ((i_lsu_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_repl(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0, then extend per funct3[2].
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_d       = req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_lsu_VALID) begin
          we_d      = i_lsu_we;
          funct3_d  = i_lsu_funct3;
          addr_lo_d = i_lsu_addr[1:0];
          if (illegal || misaligned) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d     = S_REQ;
            req_d       = 1'b1;
            bus_we_d    = i_lsu_we;
            bus_addr_d  = {i_lsu_addr[31:2], 2'b00};
            bus_be_d    = byte_en(i_lsu_funct3[1:0], i_lsu_addr[1:0]);
            bus_wdata_d = lane_repl(i_lsu_funct3[1:0], i_lsu_wdata);
          end
        end
      end
      S_REQ: begin
        if (i_bus_gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (i_bus_rvalid) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : load_ext(funct3_q, addr_lo_q, i_bus_rdata);
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      S_DONE: begin
        if (i_adv) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = 32'h0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_q       <= req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign o_lsu_READY = ready_q;
  assign o_lsu_rdata = rdata_q;
  assign o_lsu_err   = err_q;
  assign o_bus_req   = req_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_be    = bus_be_q;
  assign o_bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Expected results are pushed to a
// scoreboard when a request is issued and popped when READY is observed.
module tb_lsu_mem_responder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_lsu_VALID = 1'b0;
  logic        i_lsu_we = 1'b0;
  logic [2:0]  i_lsu_funct3 = 3'b000;
  logic [31:0] i_lsu_addr = 32'h0;
  logic [31:0] i_lsu_wdata = 32'h0;
  logic        i_adv = 1'b0;
  logic        o_lsu_READY;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = 32'h0;

  lsu_mem_responder #(.BUS_TIMEOUT(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lsu_VALID  (i_lsu_VALID),
    .i_lsu_we     (i_lsu_we),
    .i_lsu_funct3 (i_lsu_funct3),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wdata  (i_lsu_wdata),
    .i_adv        (i_adv),
    .o_lsu_READY  (o_lsu_READY),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_lsu_err    (o_lsu_err),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_gnt    (i_bus_gnt),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, o_lsu_READY}, 32'd0);
    chk({tag, "_rdata"}, o_lsu_rdata, 32'd0);
    chk({tag, "_err"},   {31'b0, o_lsu_err}, 32'd0);
    chk({tag, "_req"},   {31'b0, o_bus_req}, 32'd0);
    chk({tag, "_we"},    {31'b0, o_bus_we}, 32'd0);
    chk({tag, "_addr"},  o_bus_addr, 32'd0);
    chk({tag, "_be"},    {28'b0, o_bus_be}, 32'd0);
    chk({tag, "_wdata"}, o_bus_wdata, 32'd0);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    i_lsu_VALID  = 1'b1;
    i_lsu_we     = we;
    i_lsu_funct3 = f3;
    i_lsu_addr   = addr;
    i_lsu_wdata  = wd;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    chk({tag, "_ready"}, {31'b0, o_lsu_READY}, 32'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, o_lsu_rdata, e.rdata);
      chk({tag, "_err"},   {31'b0, o_lsu_err}, {31'b0, e.err});
    end
  endtask

  task automatic wait_ready(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && o_lsu_READY !== 1'b1; i++) step();
    expect_result(tag);
  endtask

  // Consume the result; READY must fall right after the advancing edge.
  task automatic advance(input string tag);
    i_adv = 1'b1;
    step();
    i_adv = 1'b0;
    i_lsu_VALID = 1'b0;
    chk({tag, "_ready_fall"}, {31'b0, o_lsu_READY}, 32'd0);
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be);
    chk({tag, "_req"},  {31'b0, o_bus_req}, 32'd1);
    chk({tag, "_we"},   {31'b0, o_bus_we}, {31'b0, we});
    chk({tag, "_addr"}, o_bus_addr, addr);
    chk({tag, "_be"},   {28'b0, o_bus_be}, {28'b0, be});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk_idle_outputs("reset");
    i_rst = 1'b0;

    // LB 0x1003, immediate grant, rvalid next cycle: READY at T+3
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'hFFFF_FF80, 1'b0);
    step();
    chk_bus("lb", 1'b0, 32'h0000_1000, 4'b1000);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    chk("lb_req_drop", {31'b0, o_bus_req}, 32'd0);
    chk("lb_ready_early", {31'b0, o_lsu_READY}, 32'd0);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h80FF_FF12;
    step();
    i_bus_rvalid = 1'b0;
    expect_result("lb");
    advance("lb");

    // LHU 0x2002, grant delayed: req held stable for 4 cycles
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h0000_8001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bus($sformatf("lhu_req%0d", i), 1'b0, 32'h0000_2000, 4'b1100);
      if (i == 3) i_bus_gnt = 1'b1;
    end
    step();
    i_bus_gnt = 1'b0;
    chk("lhu_req_drop", {31'b0, o_bus_req}, 32'd0);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h8001_1234;
    step();
    i_bus_rvalid = 1'b0;
    wait_ready("lhu", 4);
    advance("lhu");

    // SB 0x3001: byte lane 1, replicated data, rdata 0 after response
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h0, 1'b0);
    step();
    chk_bus("sb", 1'b1, 32'h0000_3000, 4'b0010);
    chk("sb_wdata", o_bus_wdata, 32'hABAB_ABAB);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'hDEAD_BEEF;
    step();
    i_bus_rvalid = 1'b0;
    wait_ready("sb", 4);
    advance("sb");

    // Misaligned LW and illegal funct3: error at T+1, no bus request
    issue(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 1'b1);
    step();
    chk("lw_mis_req", {31'b0, o_bus_req}, 32'd0);
    expect_result("lw_mis");
    advance("lw_mis");
    issue(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 1'b1);
    step();
    chk("f3_011_req", {31'b0, o_bus_req}, 32'd0);
    expect_result("f3_011");
    advance("f3_011");
    issue(1'b1, 3'b100, 32'h0000_4000, 32'h55, 32'h0, 1'b1);
    step();
    chk("sbu_req", {31'b0, o_bus_req}, 32'd0);
    expect_result("sbu_illegal");
    advance("sbu_illegal");

    // Timeout: rvalid never comes; READY+err after exactly 4 WAIT cycles
    issue(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 1'b1);
    step();
    chk_bus("lw_to", 1'b0, 32'h0000_5000, 4'b1111);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lw_to_wait%0d", i), {31'b0, o_lsu_READY}, 32'd0);
      step();
    end
    expect_result("lw_to");
    // Hold in DONE with a late rvalid: result must not change
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      step();
      i_bus_rvalid = 1'b0;
      chk($sformatf("hold%0d_ready", i), {31'b0, o_lsu_READY}, 32'd1);
      chk($sformatf("hold%0d_rdata", i), o_lsu_rdata, 32'd0);
      chk($sformatf("hold%0d_err", i),   {31'b0, o_lsu_err}, 32'd1);
    end
    advance("lw_to");

    // Next request after timeout is serviced normally
    issue(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1234_5678, 1'b0);
    step();
    chk_bus("lw_ok", 1'b0, 32'h0000_6000, 4'b1111);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h1234_5678;
    step();
    i_bus_rvalid = 1'b0;
    expect_result("lw_ok");
    advance("lw_ok");

    // Reset during WAIT abandons the access; stray rvalid dropped
    issue(1'b0, 3'b000, 32'h0000_7000, 32'h0, 32'h0, 1'b0);
    step();
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_lsu_VALID = 1'b0;
    sb.delete();
    chk_idle_outputs("rst_wait");
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h0000_00FF;
    step();
    i_bus_rvalid = 1'b0;
    chk("stray_ready", {31'b0, o_lsu_READY}, 32'd0);
    chk("stray_req",   {31'b0, o_bus_req}, 32'd0);

    // LH signed after reset
    issue(1'b0, 3'b001, 32'h0000_8000, 32'h0, 32'hFFFF_F234, 1'b0);
    step();
    chk_bus("lh", 1'b0, 32'h0000_8000, 4'b0011);
    i_bus_gnt = 1'b1;
    step();
    i_bus_gnt = 1'b0;
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'h0000_F234;
    step();
    i_bus_rvalid = 1'b0;
    wait_ready("lh", 4);
    advance("lh");

    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
